// File: rtl/seven_seg_pkg.sv
// Shared constants for 7-segment display blocks: active-low segment patterns
// (bit0=a .. bit6=g) and a parameter-legality helper for the scan driver.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  function automatic bit params_legal(input int num_digits, input int scan_div,
                                      input int blank_cycles);
    return (num_digits >= 1) && (num_digits <= 8) && (scan_div >= 2) &&
           (blank_cycles >= 0) && (blank_cycles < scan_div);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit code to active-low 7-segment decoder; codes 10..15 show
// hex letters when hex_en=1, otherwise a dash.
module seg7_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_en,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves seg unassigned
    // (which would infer a latch).
    seg = SEG_DASH;
    case (code)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = hex_en ? SEG_A : SEG_DASH;
      4'hB: seg = hex_en ? SEG_B : SEG_DASH;
      4'hC: seg = hex_en ? SEG_C : SEG_DASH;
      4'hD: seg = hex_en ? SEG_D : SEG_DASH;
      4'hE: seg = hex_en ? SEG_E : SEG_DASH;
      4'hF: seg = hex_en ? SEG_F : SEG_DASH;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode 7-segment driver: latches digit codes, scans one
// digit per slot with dead time, leading-zero blanking and registered outputs.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int HEX_EN       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);

  if (!params_legal(NUM_DIGITS, SCAN_DIV, BLANK_CYCLES)) begin : g_param_check
    $error("seven_seg_scan: illegal NUM_DIGITS/SCAN_DIV/BLANK_CYCLES");
  end

  logic [4*NUM_DIGITS-1:0] shadow_digits_q, shadow_digits_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0]   shadow_en_q, shadow_en_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_tick_q, frame_tick_d;

  logic [NUM_DIGITS-1:0]   blanked;
  logic                    chain;
  logic                    in_dead;
  logic                    active;
  logic [3:0]              code_cur;
  logic [6:0]              seg_dec;

  if (BLANK_CYCLES > 0) begin : g_dead
    assign in_dead = cnt_q < CNT_W'(BLANK_CYCLES);
  end else begin : g_no_dead
    assign in_dead = 1'b0;
  end

  assign code_cur = shadow_digits_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_decode (
    .code   (code_cur),
    .hex_en (HEX_EN != 0),
    .seg    (seg_dec)
  );

  always_comb begin
    shadow_digits_d = shadow_digits_q;
    shadow_dp_d     = shadow_dp_q;
    shadow_en_d     = shadow_en_q;
    if (load) begin
      shadow_digits_d = digits_in;
      shadow_dp_d     = dp_in;
      shadow_en_d     = digit_en;
    end

    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    frame_tick_d = 1'b0;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d        = '0;
        frame_tick_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    // Walk down from the top digit; a digit above that is disabled or itself
    // blanked keeps the leading-zero run going.
    blanked = '0;
    chain   = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      blanked[i] = blank_lz && (shadow_digits_q[4*i +: 4] == 4'd0) && chain;
      chain      = chain && (!shadow_en_q[i] || blanked[i]);
    end

    active = shadow_en_q[idx_q] && !blanked[idx_q] && !in_dead;

    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (active) begin
      an_d[idx_q] = 1'b0;
      seg_d       = seg_dec;
      dp_d        = ~shadow_dp_q[idx_q];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_digits_q <= '0;
      shadow_dp_q     <= '0;
      shadow_en_q     <= '0;
      cnt_q           <= '0;
      idx_q           <= '0;
      seg_q           <= SEG_OFF;
      dp_q            <= 1'b1;
      an_q            <= '1;
      frame_tick_q    <= 1'b0;
    end else begin
      shadow_digits_q <= shadow_digits_d;
      shadow_dp_q     <= shadow_dp_d;
      shadow_en_q     <= shadow_en_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      seg_q           <= seg_d;
      dp_q            <= dp_d;
      an_q            <= an_d;
      frame_tick_q    <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomized bench for seven_seg_scan: a hex build and a dash build share the
// same stimulus and are compared every cycle against a behavioural model.
module tb_seven_seg_scan;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int BL  = 1;

  logic           clk;
  logic           rst_n;
  logic           load;
  logic [4*N-1:0] digits_in;
  logic [N-1:0]   dp_in;
  logic [N-1:0]   digit_en;
  logic           blank_lz;

  logic [6:0]   seg_h, seg_x;
  logic         dp_h, dp_x;
  logic [N-1:0] an_h, an_x;
  logic         tick_h, tick_x;

  seven_seg_scan #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .BLANK_CYCLES(BL), .HEX_EN(1)) u_hex (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .digit_en(digit_en), .blank_lz(blank_lz), .seg(seg_h), .dp(dp_h), .an(an_h),
    .frame_tick(tick_h)
  );

  seven_seg_scan #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .BLANK_CYCLES(BL), .HEX_EN(0)) u_dash (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .digit_en(digit_en), .blank_lz(blank_lz), .seg(seg_x), .dp(dp_x), .an(an_x),
    .frame_tick(tick_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model state: shadow contents and scan position as plain integers.
  logic [6:0]   seg_tbl [16];
  logic [3:0]   m_code [N];
  logic [N-1:0] m_en, m_dp;
  int           m_cnt, m_idx;
  logic [6:0]   e_seg_h, e_seg_x;
  logic         e_dp, e_tick;
  logic [N-1:0] e_an;
  bit           check_en = 0;

  initial begin
    seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  end

  // A digit is a blanked leading zero when it is zero, not digit 0, and every
  // digit above it is either disabled or also zero.
  function automatic bit ref_lit(input int i, input bit blz);
    bit lead = blz && (i > 0) && (m_code[i] == 4'd0);
    for (int j = i + 1; j < N; j++)
      if (m_en[j] && m_code[j] != 4'd0) lead = 0;
    return m_en[i] && !lead;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_code[i] = 4'd0;
      m_en = '0; m_dp = '0; m_cnt = 0; m_idx = 0;
      e_seg_h = 7'h7F; e_seg_x = 7'h7F; e_dp = 1'b1; e_an = '1; e_tick = 1'b0;
    end else begin
      if (ref_lit(m_idx, blank_lz) && m_cnt >= BL) begin
        e_an    = ~(N'(1) << m_idx);
        e_seg_h = seg_tbl[m_code[m_idx]];
        e_seg_x = (m_code[m_idx] >= 10) ? 7'h3F : seg_tbl[m_code[m_idx]];
        e_dp    = ~m_dp[m_idx];
      end else begin
        e_an = '1; e_seg_h = 7'h7F; e_seg_x = 7'h7F; e_dp = 1'b1;
      end
      e_tick = (m_idx == N - 1) && (m_cnt == DIV - 1);
      if (load) begin
        for (int i = 0; i < N; i++) m_code[i] = digits_in[4*i +: 4];
        m_en = digit_en;
        m_dp = dp_in;
      end
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % N;
      end else begin
        m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("seg_hex",  {9'd0, seg_h},  {9'd0, e_seg_h});
      check("seg_dash", {9'd0, seg_x},  {9'd0, e_seg_x});
      check("dp_hex",   {15'd0, dp_h},  {15'd0, e_dp});
      check("dp_dash",  {15'd0, dp_x},  {15'd0, e_dp});
      check("an_hex",   {12'd0, an_h},  {12'd0, e_an});
      check("an_dash",  {12'd0, an_x},  {12'd0, e_an});
      check("tick_hex", {15'd0, tick_h}, {15'd0, e_tick});
      check("tick_dash", {15'd0, tick_x}, {15'd0, e_tick});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] p,
                         input logic [N-1:0] e, input logic blz);
    @(negedge clk);
    load = 1'b1; digits_in = d; dp_in = p; digit_en = e; blank_lz = blz;
    @(negedge clk);
    load = 1'b0;
  endtask

  int ticks;

  initial begin
    rst_n = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0; digit_en = '0; blank_lz = 1'b0;
    @(posedge clk);
    check_en = 1;
    idle(3);
    rst_n = 1'b1;

    // Free-run after reset: count frame ticks over three full frames.
    ticks = 0;
    for (int c = 0; c < 3 * N * DIV; c++) begin
      @(negedge clk);
      if (tick_h) ticks++;
    end
    check("frame_tick_count", 16'(ticks), 16'd3);

    do_load(16'h12AF, 4'b0100, 4'hF, 1'b0);  idle(2 * N * DIV);
    do_load(16'h0050, 4'b0000, 4'hF, 1'b1);  idle(N * DIV + 3);
    do_load(16'h0000, 4'b0000, 4'hF, 1'b1);  idle(N * DIV + 1);
    do_load(16'h9ABC, 4'b1010, 4'hF, 1'b0);  idle(N * DIV + 2);
    do_load(16'h0007, 4'b0001, 4'b0111, 1'b1); idle(N * DIV + 3);

    // Reset for one cycle while load is asserted: the load must be ignored.
    @(negedge clk);
    rst_n = 1'b0; load = 1'b1; digits_in = 16'h8888; dp_in = '1; digit_en = '1;
    @(negedge clk);
    rst_n = 1'b0 | 1'b1; load = 1'b0;
    check("rst_an",  {12'd0, an_h}, 16'h000F);
    check("rst_seg", {9'd0, seg_h}, 16'h007F);
    check("rst_dp",  {15'd0, dp_h}, 16'h0001);
    idle(N * DIV + 2);

    // Random loads at random moments, occasionally with a colliding reset.
    for (int t = 0; t < 150; t++) begin
      @(negedge clk);
      load      = 1'b1;
      digits_in = 16'($urandom);
      if ($urandom_range(0, 2) == 0) digits_in[15:8] = 8'h00;
      dp_in     = 4'($urandom);
      digit_en  = 4'($urandom);
      blank_lz  = 1'($urandom);
      rst_n     = ($urandom_range(0, 19) != 0);
      @(negedge clk);
      load  = 1'b0;
      rst_n = 1'b1;
      idle($urandom_range(0, 2 * N * DIV));
    end

    idle(2);
    check_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
